// File: rtl/ddr_dly_pkg.sv
// Shared types and constants for the per-lane IOD delay-line training controller.
package ddr_dly_pkg;

  localparam int TAP_W = 8;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    CLEAR,
    SETTLE,
    SAMPLE,
    STEP,
    CHECK,
    DONE,
    ERR
  } train_state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_OOR     = 2'd1;
  localparam logic [1:0] ERR_BOUND   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/ddr_dly_train_ctrl_if.sv
// Control, status and IOD/eye-monitor signals of one training lane.
interface ddr_dly_train_ctrl_if;
  import ddr_dly_pkg::*;

  logic             start;
  logic             abort;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       err_code;
  logic [TAP_W-1:0] tap_val;
  logic             dl_load;
  logic             dl_move;
  logic             dl_dir;
  logic             em_clear;
  logic             em_early;
  logic             em_late;
  logic             dl_oor;

  modport master (
    input  start, abort, em_early, em_late, dl_oor,
    output busy, done, err, err_code, tap_val, dl_load, dl_move, dl_dir, em_clear
  );

  modport slave (
    output start, abort, em_early, em_late, dl_oor,
    input  busy, done, err, err_code, tap_val, dl_load, dl_move, dl_dir, em_clear
  );

endinterface

// File: rtl/ddr_dly_train_ctrl.sv
// Per-lane delay-line training FSM: walks the IOD tap towards the eye centre
// using the eye-monitor early/late flags and reports lock, tap and failure cause.
module ddr_dly_train_ctrl
  import ddr_dly_pkg::*;
#(
  parameter int unsigned      SETTLE_CYCLES = 8,
  parameter int unsigned      LOCK_COUNT    = 4,
  parameter logic [TAP_W-1:0] MAX_TAP       = 8'd127,
  parameter logic [15:0]      MAX_ITER      = 16'd1024
) (
  input logic                  FAB_CLK,
  input logic                  ARST_N,
  ddr_dly_train_ctrl_if.master bus
);

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0] LOCK_N    = 4'(LOCK_COUNT);

  train_state_t     state;
  logic [7:0]       settle_cnt;
  logic [3:0]       lock_cnt;
  logic [15:0]      iter_cnt;
  logic [15:0]      iter_nxt;
  logic             early_q;
  logic             late_q;

  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       err_code;
  logic [TAP_W-1:0] tap_val;
  logic             dl_load;
  logic             dl_move;
  logic             dl_dir;
  logic             em_clear;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [TAP_W-1:0] tap_step(input logic [TAP_W-1:0] v, input logic up);
    return up ? v + TAP_W'(1) : v - TAP_W'(1);
  endfunction

  assign iter_nxt = sat_inc16(iter_cnt);

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      tap_val    <= '0;
      dl_load    <= 1'b0;
      dl_move    <= 1'b0;
      dl_dir     <= 1'b0;
      em_clear   <= 1'b0;
      settle_cnt <= '0;
      lock_cnt   <= '0;
      iter_cnt   <= '0;
      early_q    <= 1'b0;
      late_q     <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      dl_load  <= 1'b0;
      dl_move  <= 1'b0;
      em_clear <= 1'b0;
      if (bus.abort) begin
        state  <= IDLE;
        busy   <= 1'b0;
        dl_dir <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (bus.start) begin
            state    <= LOAD;
            busy     <= 1'b1;
            dl_load  <= 1'b1;
            err_code <= ERR_NONE;
            tap_val  <= '0;
            lock_cnt <= '0;
            iter_cnt <= '0;
          end
          LOAD: begin
            tap_val  <= '0;
            em_clear <= 1'b1;
            state    <= CLEAR;
          end
          CLEAR: begin
            settle_cnt <= SETTLE_LD;
            state      <= SETTLE;
          end
          // Direction is registered one cycle ahead of dl_move so it is stable when the move strobe rises.
          SETTLE: if (settle_cnt == 8'd0) begin
            state   <= SAMPLE;
            early_q <= bus.em_early;
            late_q  <= bus.em_late;
            if (bus.em_early ^ bus.em_late) dl_dir <= bus.em_early;
          end else begin
            settle_cnt <= settle_cnt - 8'd1;
          end
          SAMPLE: begin
            iter_cnt <= iter_nxt;
            if (iter_nxt == MAX_ITER) begin
              state <= ERR; err <= 1'b1; busy <= 1'b0; err_code <= ERR_TIMEOUT;
            end else if (early_q && !late_q && tap_val == MAX_TAP) begin
              state <= ERR; err <= 1'b1; busy <= 1'b0; err_code <= ERR_BOUND;
            end else if (late_q && !early_q && tap_val == '0) begin
              state <= ERR; err <= 1'b1; busy <= 1'b0; err_code <= ERR_BOUND;
            end else if (early_q ^ late_q) begin
              lock_cnt <= '0;
              dl_move  <= 1'b1;
              state    <= STEP;
            end else if (early_q) begin
              lock_cnt <= '0;
              em_clear <= 1'b1;
              state    <= CLEAR;
            end else if (lock_cnt + 4'd1 == LOCK_N) begin
              state <= DONE; done <= 1'b1; busy <= 1'b0;
            end else begin
              lock_cnt <= lock_cnt + 4'd1;
              em_clear <= 1'b1;
              state    <= CLEAR;
            end
          end
          STEP: begin
            tap_val <= tap_step(tap_val, dl_dir);
            state   <= CHECK;
          end
          CHECK: if (bus.dl_oor) begin
            state <= ERR; err <= 1'b1; busy <= 1'b0; err_code <= ERR_OOR;
          end else begin
            em_clear <= 1'b1;
            state    <= CLEAR;
          end
          DONE:    state <= IDLE;
          ERR:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.err      = err;
  assign bus.err_code = err_code;
  assign bus.tap_val  = tap_val;
  assign bus.dl_load  = dl_load;
  assign bus.dl_move  = dl_move;
  assign bus.dl_dir   = dl_dir;
  assign bus.em_clear = em_clear;

endmodule

// File: tb/tb_ddr_dly_train_ctrl.sv
// Bench for ddr_dly_train_ctrl: an IOD/eye-monitor model drives the flags and a
// sample-level reference model predicts outcome, final tap, move count and latency.
module tb_ddr_dly_train_ctrl;
  import ddr_dly_pkg::*;

  localparam int SETTLE = 8;
  localparam int LOCK   = 4;
  localparam int MAXTAP = 127;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic sel = 1'b0, start = 1'b0, abort = 1'b0;
  logic em_early = 1'b0, em_late = 1'b0, dl_oor = 1'b0;

  ddr_dly_train_ctrl_if bus_a ();
  ddr_dly_train_ctrl_if bus_b ();

  assign bus_a.start = start & ~sel;
  assign bus_b.start = start & sel;
  assign bus_a.abort = abort & ~sel;
  assign bus_b.abort = abort & sel;
  assign bus_a.em_early = em_early;
  assign bus_b.em_early = em_early;
  assign bus_a.em_late  = em_late;
  assign bus_b.em_late  = em_late;
  assign bus_a.dl_oor   = dl_oor;
  assign bus_b.dl_oor   = dl_oor;

  ddr_dly_train_ctrl dut_a (.FAB_CLK(clk), .ARST_N(rst_n), .bus(bus_a));
  ddr_dly_train_ctrl #(.MAX_ITER(16'd16)) dut_b (.FAB_CLK(clk), .ARST_N(rst_n), .bus(bus_b));

  logic o_busy, o_done, o_err, o_load, o_move, o_dir, o_clear;
  logic [1:0] o_code;
  logic [7:0] o_tap;
  assign o_busy  = sel ? bus_b.busy     : bus_a.busy;
  assign o_done  = sel ? bus_b.done     : bus_a.done;
  assign o_err   = sel ? bus_b.err      : bus_a.err;
  assign o_load  = sel ? bus_b.dl_load  : bus_a.dl_load;
  assign o_move  = sel ? bus_b.dl_move  : bus_a.dl_move;
  assign o_dir   = sel ? bus_b.dl_dir   : bus_a.dl_dir;
  assign o_clear = sel ? bus_b.em_clear : bus_a.em_clear;
  assign o_code  = sel ? bus_b.err_code : bus_a.err_code;
  assign o_tap   = sel ? bus_b.tap_val  : bus_a.tap_val;

  int n_checks = 0;
  int n_errors = 0;

  int r_cyc, r_load, r_clear, r_move, r_up, r_baddir, r_badbusy;
  bit r_done, r_err;

  // Sample-level reference: mode 0 = eye centred at tgt, mode 1 = early/late alternate per sample.
  function automatic void predict(input int mode, input int tgt, input bit oor, input int max_iter,
                                  output int code, output int tap, output int moves,
                                  output int cycles, output int samples);
    int lock;
    bit e, l;
    code = -1; tap = 0; moves = 0; cycles = 1; samples = 0; lock = 0;
    while (code < 0) begin
      cycles += SETTLE + 2;
      samples++;
      if (mode == 0) begin e = (tap < tgt); l = (tap > tgt); end
      else begin e = (samples % 2 == 1); l = !e; end
      if (samples == max_iter) begin code = 3; cycles++; end
      else if (e && !l) begin
        if (tap == MAXTAP) begin code = 2; cycles++; end
        else begin tap++; moves++; lock = 0; cycles += 2; if (oor) begin code = 1; cycles++; end end
      end else if (l && !e) begin
        if (tap == 0) begin code = 2; cycles++; end
        else begin tap--; moves++; lock = 0; cycles += 2; if (oor) begin code = 1; cycles++; end end
      end else if (!e && !l) begin
        lock++;
        if (lock == LOCK) begin code = 0; cycles++; end
      end else lock = 0;
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic run_train(input int mode, input int tgt, input bit oor, input int restart_at);
    int mtap, oor_cnt;
    bit prev_dir, use_oor;
    mtap = 0; oor_cnt = 0; use_oor = oor; prev_dir = o_dir;
    r_load = 0; r_clear = 0; r_move = 0; r_up = 0; r_baddir = 0; r_badbusy = 0;
    r_done = 0; r_err = 0;
    start = 1'b1; @(posedge clk); #1; start = 1'b0; r_cyc = 1;
    while (r_cyc <= 4000) begin
      start = (r_cyc == restart_at);
      if (o_load) begin r_load++; mtap = 0; end
      if (o_clear) r_clear++;
      if (o_move) begin
        r_move++;
        if (o_dir !== prev_dir) r_baddir++;
        if (o_dir !== em_early) r_baddir++;
        if (o_dir) begin mtap++; r_up++; end else mtap--;
        if (use_oor) begin oor_cnt = 2; use_oor = 0; end
      end
      if (oor_cnt > 0) begin dl_oor = 1'b1; oor_cnt--; end else dl_oor = 1'b0;
      if (!o_busy && !o_done && !o_err) r_badbusy++;
      if (o_busy && (o_done || o_err)) r_badbusy++;
      if (o_done || o_err) begin r_done = o_done; r_err = o_err; break; end
      prev_dir = o_dir;
      if (mode == 0) begin em_early = (mtap < tgt); em_late = (mtap > tgt); end
      else begin em_early = (r_clear % 2 == 1); em_late = (r_clear % 2 == 0); end
      @(posedge clk); #1; r_cyc++;
    end
    start = 1'b0; dl_oor = 1'b0; em_early = 1'b0; em_late = 1'b0;
    n_checks++; if (!(r_done || r_err)) begin n_errors++; $display("FAIL run_bound: no done/err after %0d cycles, required one within 4000", r_cyc); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(3);
    n_checks++; if ({o_busy, o_done, o_err, o_load, o_move, o_dir, o_clear} !== 7'b0) begin n_errors++; $display("FAIL reset_ctrl: got %b required 0000000", {o_busy, o_done, o_err, o_load, o_move, o_dir, o_clear}); end
    n_checks++; if (o_code !== 2'd0) begin n_errors++; $display("FAIL reset_code: got %0d required 0", o_code); end
    n_checks++; if (o_tap !== 8'd0) begin n_errors++; $display("FAIL reset_tap: got %0d required 0", o_tap); end
    rst_n = 1'b1; idle(3);
    n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL idle_busy: got %b required 0", o_busy); end
  endtask

  task automatic test_centred();
    int pc, pt, pm, pcy, ps;
    predict(0, 0, 1'b0, 1024, pc, pt, pm, pcy, ps);
    run_train(0, 0, 1'b0, 0);
    n_checks++; if (r_cyc !== 42) begin n_errors++; $display("FAIL centred_latency: got %0d required 42", r_cyc); end
    n_checks++; if (r_done !== 1'b1 || o_code !== 2'd0) begin n_errors++; $display("FAIL centred_done: got done=%b code=%0d required done=1 code=0", r_done, o_code); end
    n_checks++; if (o_tap !== 8'(pt)) begin n_errors++; $display("FAIL centred_tap: got %0d required %0d", o_tap, pt); end
    n_checks++; if (r_load !== 1 || r_clear !== ps) begin n_errors++; $display("FAIL centred_strobes: got load=%0d clear=%0d required load=1 clear=%0d", r_load, r_clear, ps); end
    n_checks++; if (r_move !== 0 || r_badbusy !== 0) begin n_errors++; $display("FAIL centred_move_busy: got moves=%0d busy_faults=%0d required 0 0", r_move, r_badbusy); end
    idle(3);
  endtask

  task automatic test_early_walk();
    int pc, pt, pm, pcy, ps;
    predict(0, 5, 1'b0, 1024, pc, pt, pm, pcy, ps);
    run_train(0, 5, 1'b0, 0);
    n_checks++; if (r_move !== 5 || r_up !== 5) begin n_errors++; $display("FAIL walk_moves: got moves=%0d up=%0d required 5 5", r_move, r_up); end
    n_checks++; if (r_done !== 1'b1 || o_tap !== 8'd5) begin n_errors++; $display("FAIL walk_result: got done=%b tap=%0d required done=1 tap=5", r_done, o_tap); end
    n_checks++; if (r_cyc !== pcy) begin n_errors++; $display("FAIL walk_latency: got %0d required %0d", r_cyc, pcy); end
    n_checks++; if (r_baddir !== 0 || r_badbusy !== 0) begin n_errors++; $display("FAIL walk_dir_busy: got dir_faults=%0d busy_faults=%0d required 0 0", r_baddir, r_badbusy); end
    idle(3);
  endtask

  task automatic test_random();
    int pc, pt, pm, pcy, ps, tgt, rs;
    for (int i = 0; i < 4; i++) begin
      tgt = int'($urandom_range(0, 40));
      rs  = int'($urandom_range(2, 30));
      predict(0, tgt, 1'b0, 1024, pc, pt, pm, pcy, ps);
      run_train(0, tgt, 1'b0, rs);
      n_checks++; if (r_cyc !== pcy || r_done !== 1'b1) begin n_errors++; $display("FAIL rand_latency[%0d]: tgt=%0d got cyc=%0d done=%b required cyc=%0d done=1", i, tgt, r_cyc, r_done, pcy); end
      n_checks++; if (o_tap !== 8'(pt) || r_move !== pm || r_baddir !== 0) begin n_errors++; $display("FAIL rand_tap[%0d]: got tap=%0d moves=%0d dir_faults=%0d required tap=%0d moves=%0d 0", i, o_tap, r_move, r_baddir, pt, pm); end
      idle(3);
    end
  endtask

  task automatic test_late_at_zero();
    int pc, pt, pm, pcy, ps;
    predict(0, -1, 1'b0, 1024, pc, pt, pm, pcy, ps);
    run_train(0, -1, 1'b0, 0);
    n_checks++; if (r_err !== 1'b1 || o_code !== 2'(pc)) begin n_errors++; $display("FAIL late0_err: got err=%b code=%0d required err=1 code=%0d", r_err, o_code, pc); end
    n_checks++; if (o_tap !== 8'd0 || r_move !== 0 || r_cyc !== pcy) begin n_errors++; $display("FAIL late0_tap: got tap=%0d moves=%0d cyc=%0d required 0 0 %0d", o_tap, r_move, r_cyc, pcy); end
    idle(3);
  endtask

  task automatic test_max_tap();
    int pc, pt, pm, pcy, ps;
    predict(0, 200, 1'b0, 1024, pc, pt, pm, pcy, ps);
    run_train(0, 200, 1'b0, 0);
    n_checks++; if (r_err !== 1'b1 || o_code !== 2'd2) begin n_errors++; $display("FAIL maxtap_err: got err=%b code=%0d required err=1 code=2", r_err, o_code); end
    n_checks++; if (o_tap !== 8'(pt) || r_move !== pm || r_cyc !== pcy) begin n_errors++; $display("FAIL maxtap_tap: got tap=%0d moves=%0d cyc=%0d required %0d %0d %0d", o_tap, r_move, r_cyc, pt, pm, pcy); end
    idle(3);
  endtask

  task automatic test_oor();
    int pc, pt, pm, pcy, ps;
    predict(0, 5, 1'b1, 1024, pc, pt, pm, pcy, ps);
    run_train(0, 5, 1'b1, 0);
    n_checks++; if (r_err !== 1'b1 || o_code !== 2'd1) begin n_errors++; $display("FAIL oor_err: got err=%b code=%0d required err=1 code=1", r_err, o_code); end
    n_checks++; if (o_tap !== 8'd1 || r_cyc !== pcy) begin n_errors++; $display("FAIL oor_tap: got tap=%0d cyc=%0d required tap=1 cyc=%0d", o_tap, r_cyc, pcy); end
  endtask

  task automatic test_err_hold();
    idle(5);
    n_checks++; if (o_code !== 2'd1 || o_tap !== 8'd1 || o_busy !== 1'b0) begin n_errors++; $display("FAIL hold_after_err: got code=%0d tap=%0d busy=%b required 1 1 0", o_code, o_tap, o_busy); end
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    n_checks++; if (o_code !== 2'd0 || o_tap !== 8'd0 || o_busy !== 1'b1 || o_load !== 1'b1) begin n_errors++; $display("FAIL restart_clear: got code=%0d tap=%0d busy=%b load=%b required 0 0 1 1", o_code, o_tap, o_busy, o_load); end
    abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
    idle(2);
  endtask

  task automatic test_timeout();
    int pc, pt, pm, pcy, ps;
    sel = 1'b1;
    predict(1, 0, 1'b0, 16, pc, pt, pm, pcy, ps);
    run_train(1, 0, 1'b0, 0);
    n_checks++; if (r_err !== 1'b1 || o_code !== 2'd3) begin n_errors++; $display("FAIL timeout_err: got err=%b code=%0d required err=1 code=3", r_err, o_code); end
    n_checks++; if (r_clear !== 16 || o_tap !== 8'(pt) || r_cyc !== pcy) begin n_errors++; $display("FAIL timeout_count: got samples=%0d tap=%0d cyc=%0d required 16 %0d %0d", r_clear, o_tap, r_cyc, pt, pcy); end
    idle(3);
    sel = 1'b0;
  endtask

  task automatic test_abort_settle();
    int mtap, moves, events;
    bit cleared;
    mtap = 0; moves = 0; cleared = 0; events = 0;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    for (int c = 0; c < 400 && !cleared; c++) begin
      if (o_move) begin moves++; mtap += o_dir ? 1 : -1; end
      if (o_clear && moves == 2) cleared = 1;
      if (o_done || o_err) events++;
      em_early = (mtap < 3); em_late = (mtap > 3);
      @(posedge clk); #1;
    end
    idle(2);
    n_checks++; if (!cleared || events !== 0) begin n_errors++; $display("FAIL abort_reach: got settle_reached=%b pulses=%0d required 1 0", cleared, events); end
    abort = 1'b1; @(posedge clk); #1; abort = 1'b0;
    n_checks++; if ({o_busy, o_done, o_err, o_load, o_move, o_clear} !== 6'b0) begin n_errors++; $display("FAIL abort_strobes: got %b required 000000", {o_busy, o_done, o_err, o_load, o_move, o_clear}); end
    n_checks++; if (o_tap !== 8'd2 || o_code !== 2'd0) begin n_errors++; $display("FAIL abort_hold: got tap=%0d code=%0d required 2 0", o_tap, o_code); end
    events = 0;
    for (int c = 0; c < 40; c++) begin
      if (o_busy || o_done || o_err || o_load || o_move || o_clear) events++;
      @(posedge clk); #1;
    end
    n_checks++; if (events !== 0) begin n_errors++; $display("FAIL abort_quiet: got %0d active cycles required 0", events); end
    em_early = 1'b0; em_late = 1'b0;
  endtask

  task automatic test_arst_step();
    int mtap, moves, events;
    mtap = 0; moves = 0; events = 0;
    start = 1'b1; @(posedge clk); #1; start = 1'b0;
    for (int c = 0; c < 400 && moves < 2; c++) begin
      if (o_move) begin moves++; mtap += o_dir ? 1 : -1; end
      if (o_done || o_err) events++;
      if (moves < 2) begin
        em_early = (mtap < 3); em_late = (mtap > 3);
        @(posedge clk); #1;
      end
    end
    n_checks++; if (moves !== 2 || o_move !== 1'b1 || o_tap !== 8'd1) begin n_errors++; $display("FAIL arst_reach: got moves=%0d move=%b tap=%0d required 2 1 1", moves, o_move, o_tap); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({o_busy, o_done, o_err, o_load, o_move, o_dir, o_clear} !== 7'b0 || o_tap !== 8'd0 || o_code !== 2'd0) begin n_errors++; $display("FAIL arst_async: got ctrl=%b tap=%0d code=%0d required 0000000 0 0", {o_busy, o_done, o_err, o_load, o_move, o_dir, o_clear}, o_tap, o_code); end
    @(posedge clk); #1; rst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (o_busy || o_done || o_err || o_load || o_move || o_clear) events++;
      @(posedge clk); #1;
    end
    n_checks++; if (events !== 0) begin n_errors++; $display("FAIL arst_quiet: got %0d active cycles required 0", events); end
    em_early = 1'b0; em_late = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t, required finish before 600000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_centred();
    test_early_walk();
    test_random();
    test_late_at_zero();
    test_max_tap();
    test_oor();
    test_err_hold();
    test_timeout();
    test_abort_settle();
    test_arst_step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
